// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mult_pkg
// Brief   : Shared state encoding for the shift-and-add multiplier sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_step_counter.sv
`default_nettype none
// ============================================================================
// Module  : mult_step_counter
// Brief   : Saturating shift-step counter with clear and last-step flag.
// Revision: 1.0 - initial release
// ============================================================================
module mult_step_counter #(
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          n_reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != CW'(N))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CW'(N - 1));

endmodule
`default_nettype wire

// File: rtl/mult_sequencer_n.sv
`default_nettype none
// ============================================================================
// Module  : mult_sequencer_n
// Brief   : Control FSM for an N-bit shift-and-add multiplier datapath.
// Revision: 1.0 - initial release
// ============================================================================
module mult_sequencer_n
    import mult_pkg::*;
#(
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          n_reset,
    input  logic          start,
    input  logic          abort,
    input  logic          early_en,
    input  logic          Q0,
    input  logic          Qz,
    output logic          resetout,
    output logic          add,
    output logic          shift,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    state_t state_q, state_d;
    logic   resetout_q, resetout_d;
    logic   add_q, add_d;
    logic   shift_q, shift_d;
    logic   ready_q, ready_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   last_step;

    // Counter follows the state actually presented to the datapath, so a
    // SHIFT cut short by abort still counts the shift that was performed.
    mult_step_counter #(
        .N (N)
    ) u_step_counter (
        .clock   (clock),
        .n_reset (n_reset),
        .clear   (state_q == LOAD),
        .inc     (state_q == SHIFT),
        .count   (count),
        .last    (last_step)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = EVAL;
            EVAL: begin
                if (early_en && Qz) state_d = DONE;
                else if (Q0)        state_d = ADD;
                else                state_d = SHIFT;
            end
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = last_step ? DONE : EVAL;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;

        // Outputs are registered copies of the decode of the next state.
        resetout_d = (state_d == LOAD);
        add_d      = (state_d == ADD);
        shift_d    = (state_d == SHIFT);
        ready_d    = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            resetout_q <= 1'b0;
            add_q      <= 1'b0;
            shift_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            resetout_q <= resetout_d;
            add_q      <= add_d;
            shift_q    <= shift_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign resetout = resetout_q;
    assign add      = add_q;
    assign shift    = shift_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire
